// File: rtl/movi_seq.sv
// ============================================================================
// movi_seq : multi-word move-immediate sequencer (ZX / SX / MOVHI writeback)
// Rev 1.0
// ============================================================================
`default_nettype none

module movi_seq #(
    parameter int DATA_W    = 16,
    parameter int IMM_W     = 8,
    parameter int MAX_WORDS = 2,
    parameter int REG_AW    = 3,
    parameter int NW_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [NW_W-1:0]   nwords_i,
    input  logic [REG_AW-1:0] dest_addr_i,
    input  logic [IMM_W-1:0]  imm_data_i,
    input  logic              imm_valid_i,
    output logic              imm_req_o,
    output logic              pc_inc_o,
    input  logic [DATA_W-1:0] reg_rd_data_i,
    output logic              reg_wr_en_o,
    output logic [REG_AW-1:0] reg_wr_addr_o,
    output logic [DATA_W-1:0] reg_wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              illegal_o
);

    localparam int ACC_W  = MAX_WORDS * IMM_W;
    localparam int EXT_W  = (ACC_W > DATA_W) ? ACC_W : DATA_W;
    localparam int HALF_W = DATA_W / 2;

    localparam logic [1:0] MODE_ZX = 2'b00;
    localparam logic [1:0] MODE_SX = 2'b01;
    localparam logic [1:0] MODE_HI = 2'b10;
    localparam logic [1:0] MODE_RS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [NW_W-1:0]     cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [NW_W-1:0]     nwords_q, nwords_d;
    logic [REG_AW-1:0]   dest_q, dest_d;
    logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, done_q, illegal_q, illegal_d;
    logic                pc_inc;
    logic [DATA_W-1:0]   wr_val;

    logic [EXT_W-1:0]    acc_ext, sx_ext;
    logic                sign_bit;
    int                  load_w;
    logic                unused_rd_hi;

    assign unused_rd_hi = ^reg_rd_data_i[DATA_W-1:HALF_W];

    // Bits above the loaded width are always zero, so zero-extend is a plain resize.
    always_comb begin
        acc_ext  = EXT_W'(acc_q);
        load_w   = int'(nwords_q) * IMM_W;
        sign_bit = 1'b0;
        sx_ext   = '0;
        for (int i = 0; i < EXT_W; i++) begin
            if (i == load_w - 1) sign_bit = acc_ext[i];
        end
        for (int i = 0; i < EXT_W; i++) begin
            sx_ext[i] = (i < load_w) ? acc_ext[i] : sign_bit;
        end
        case (mode_q)
            MODE_SX: wr_val = sx_ext[DATA_W-1:0];
            MODE_HI: wr_val = {acc_ext[HALF_W-1:0], reg_rd_data_i[HALF_W-1:0]};
            default: wr_val = acc_ext[DATA_W-1:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        nwords_d  = nwords_q;
        dest_d    = dest_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        illegal_d = 1'b0;
        pc_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    nwords_d = nwords_i;
                    dest_d   = dest_addr_i;
                    if (mode_i == MODE_RS || nwords_i == '0 ||
                        nwords_i > NW_W'(MAX_WORDS)) begin
                        illegal_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (imm_valid_i) begin
                    pc_inc = 1'b1;
                    acc_d  = (acc_q << IMM_W) | ACC_W'(imm_data_i);
                    cnt_d  = cnt_q + NW_W'(1);
                    if (cnt_d == nwords_q) begin
                        wr_addr_d = dest_q;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wr_data_d = wr_val;
                state_d   = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
            nwords_q  <= '0;
            dest_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            nwords_q  <= nwords_d;
            dest_q    <= dest_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= (state_d == S_WRITE);
            done_q    <= (state_d == S_DONE);
            illegal_q <= illegal_d;
        end
    end

    // MOVHI needs reg_rd_data live in the write cycle, hence the bypass mux.
    assign reg_wr_data_o = wr_en_q ? wr_val : wr_data_q;
    assign reg_wr_addr_o = wr_addr_q;
    assign reg_wr_en_o   = wr_en_q;
    assign done_o        = done_q;
    assign illegal_o     = illegal_q;
    assign imm_req_o     = (state_q == S_FETCH);
    assign busy_o        = (state_q == S_FETCH) || (state_q == S_WRITE);
    assign pc_inc_o      = pc_inc;

endmodule

`default_nettype wire

// File: tb/tb_movi_seq.sv
// ============================================================================
// tb_movi_seq : timeline-based self-checking bench for movi_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_movi_seq;

    localparam int DATA_W    = 16;
    localparam int IMM_W     = 8;
    localparam int MAX_WORDS = 2;
    localparam int REG_AW    = 3;
    localparam int NW_W      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [NW_W-1:0]   nwords;
    logic [REG_AW-1:0] dest;
    logic [IMM_W-1:0]  imm_data;
    logic              imm_valid;
    logic              imm_req;
    logic              pc_inc;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              illegal;

    always #5 clk = ~clk;

    movi_seq #(
        .DATA_W(DATA_W), .IMM_W(IMM_W), .MAX_WORDS(MAX_WORDS),
        .REG_AW(REG_AW), .NW_W(NW_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode),
        .nwords_i(nwords), .dest_addr_i(dest), .imm_data_i(imm_data),
        .imm_valid_i(imm_valid), .imm_req_o(imm_req), .pc_inc_o(pc_inc),
        .reg_rd_data_i(rd_data), .reg_wr_en_o(wr_en), .reg_wr_addr_o(wr_addr),
        .reg_wr_data_o(wr_data), .busy_o(busy), .done_o(done), .illegal_o(illegal)
    );

    typedef struct packed {
        logic              req, inc, bsy, wen, dn, ill;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              q[$];
    exp_t              ce;
    int                n_checks = 0;
    int                n_errs   = 0;
    logic [REG_AW-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".imm_req"}, 32'(imm_req), 32'(e.req));
        chk({tag, ".pc_inc"},  32'(pc_inc),  32'(e.inc));
        chk({tag, ".busy"},    32'(busy),    32'(e.bsy));
        chk({tag, ".wr_en"},   32'(wr_en),   32'(e.wen));
        chk({tag, ".done"},    32'(done),    32'(e.dn));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(e.addr));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(e.data));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            chk_all("cyc", ce);
        end
    end

    function automatic exp_t idle_e();
        exp_t e;
        e      = '0;
        e.addr = last_addr;
        e.data = last_data;
        return e;
    endfunction

    // Reference result from the arithmetic definition of each write mode.
    function automatic logic [DATA_W-1:0] model(input int m, input int n,
                                                input logic [IMM_W-1:0] w0, input logic [IMM_W-1:0] w1,
                                                input logic [DATA_W-1:0] rd);
        longint acc, lw, full, half;
        acc  = longint'(w0);
        if (n == 2) acc = acc * (longint'(1) << IMM_W) + longint'(w1);
        lw   = longint'(1) << (n * IMM_W);
        full = longint'(1) << DATA_W;
        half = longint'(1) << (DATA_W / 2);
        case (m)
            1: if (acc >= lw / 2) acc = acc - lw;
            2: acc = (acc % half) * half + (longint'(rd) % half);
            default: ;
        endcase
        acc = acc % full;
        if (acc < 0) acc = acc + full;
        return DATA_W'(acc);
    endfunction

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic stray(input bit noise);
        if (noise) begin
            start  = 1'($urandom);
            mode   = 2'($urandom);
            nwords = NW_W'($urandom);
            dest   = REG_AW'($urandom);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic run_instr(input int m, input int n, input logic [REG_AW-1:0] d,
                             input logic [IMM_W-1:0] w0, input logic [IMM_W-1:0] w1,
                             input int g0, input int g1,
                             input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] exp_data,
                             input bit noise);
        exp_t e;
        bit   legal;
        int   g;
        start     = 1'b1;
        mode      = 2'(m);
        nwords    = NW_W'(n);
        dest      = d;
        imm_valid = noise ? 1'($urandom) : 1'b0;
        imm_data  = IMM_W'($urandom);
        rd_data   = DATA_W'($urandom);
        step(idle_e());
        legal = (m != 3) && (n >= 1) && (n <= MAX_WORDS);
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                g = (k == 0) ? g0 : g1;
                for (int j = 0; j < g; j++) begin
                    stray(noise);
                    imm_valid = 1'b0;
                    imm_data  = IMM_W'($urandom);
                    e = idle_e(); e.req = 1'b1; e.bsy = 1'b1;
                    step(e);
                end
                stray(noise);
                imm_valid = 1'b1;
                imm_data  = (k == 0) ? w0 : w1;
                e = idle_e(); e.req = 1'b1; e.inc = 1'b1; e.bsy = 1'b1;
                step(e);
            end
            stray(noise);
            imm_valid = noise ? 1'($urandom) : 1'b0;
            imm_data  = IMM_W'($urandom);
            rd_data   = rd;
            last_addr = d;
            last_data = exp_data;
            e = idle_e(); e.wen = 1'b1; e.bsy = 1'b1;
            step(e);
        end else begin
            stray(noise);
        end
        imm_valid = noise ? 1'($urandom) : 1'b0;
        rd_data   = DATA_W'($urandom);
        e = idle_e(); e.dn = 1'b1; e.ill = !legal;
        step(e);
        start     = 1'b0;
        imm_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   m, n;
        logic [IMM_W-1:0]  w0, w1;
        logic [DATA_W-1:0] rd;
        rst_n = 1'b0; start = 1'b0; mode = '0; nwords = '0; dest = '0;
        imm_data = '0; imm_valid = 1'b0; rd_data = '0;
        #12;
        chk_all("reset", idle_e());
        @(negedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(0, 1, 3'd3, 8'h85, 8'h00, 0, 0, 16'h0000, 16'h0085, 1'b0);
        run_instr(1, 1, 3'd2, 8'h85, 8'h00, 0, 0, 16'h0000, 16'hFF85, 1'b0);
        run_instr(1, 1, 3'd2, 8'h45, 8'h00, 0, 0, 16'h0000, 16'h0045, 1'b0);
        run_instr(0, 2, 3'd1, 8'h12, 8'h34, 0, 2, 16'h0000, 16'h1234, 1'b0);
        run_instr(2, 1, 3'd3, 8'h5E, 8'h00, 0, 0, 16'hABCD, 16'h5ECD, 1'b0);
        run_instr(3, 1, 3'd6, 8'h11, 8'h00, 0, 0, 16'h0000, 16'h0000, 1'b1);
        run_instr(0, 0, 3'd6, 8'h11, 8'h00, 0, 0, 16'h0000, 16'h0000, 1'b0);
        run_instr(0, 3, 3'd6, 8'h11, 8'h00, 0, 0, 16'h0000, 16'h0000, 1'b0);

        // Abort a two-word instruction after its first word.
        start = 1'b1; mode = 2'd0; nwords = 2'd2; dest = 3'd5;
        step(idle_e());
        start = 1'b0; imm_valid = 1'b1; imm_data = 8'h12;
        e = idle_e(); e.req = 1'b1; e.inc = 1'b1; e.bsy = 1'b1;
        step(e);
        imm_valid = 1'b0;
        e = idle_e(); e.req = 1'b1; e.bsy = 1'b1;
        q.push_back(e);
        @(negedge clk); #2;
        rst_n = 1'b0; imm_valid = 1'b1;
        last_addr = '0; last_data = '0;
        #1;
        chk_all("async_rst", idle_e());
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_all("in_rst", idle_e());
        end
        #1; imm_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        run_instr(0, 1, 3'd4, 8'h7F, 8'h00, 0, 0, 16'h0000, 16'h007F, 1'b0);

        for (int t = 0; t < 80; t++) begin
            m  = int'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 3));
            w0 = IMM_W'($urandom);
            w1 = IMM_W'($urandom);
            rd = DATA_W'($urandom);
            run_instr(m, n, REG_AW'($urandom), w0, w1,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      rd, model(m, n, w0, w1, rd), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                imm_valid = 1'($urandom);
                imm_data  = IMM_W'($urandom);
                step(idle_e());
                imm_valid = 1'b0;
            end
        end

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/movi_seq.md
Name: movi_seq

Overview:
- Parametrised move-immediate execution sequencer for the microcontroller datapath. It is the successor to the fixed single-word MOVI controller.
- On `start` it fetches 1..MAX_WORDS immediate words from program memory through a valid-qualified request, pulsing PC increment once per accepted word. It assembles the words, then writes the destination register in one of three modes: zero-extend, sign-extend, or load-high.
- It flags illegal encodings and signals completion to the instruction decoder.

Parameters:
- DATA_W, 16, register file data width (even, >= IMM_W)
- IMM_W, 8, width of one immediate word fetched from program memory
- MAX_WORDS, 2, maximum immediate words per instruction (>= 1)
- REG_AW, 3, register address width
- NW_W, $clog2(MAX_WORDS+1), width of the word-count input (derived)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin instruction; sampled only in IDLE
- mode  in  2  00 MOVI zero-extend, 01 MOVI sign-extend, 10 MOVHI, 11 reserved
- nwords  in  NW_W  number of immediate words to fetch
- dest_addr  in  REG_AW  destination register
- imm_data  in  IMM_W  immediate word from program memory
- imm_valid  in  1  imm_data valid this cycle
- imm_req  out  1  requesting next immediate word
- pc_inc  out  1  one-cycle pulse per accepted immediate word
- reg_rd_data  in  DATA_W  current value of destination register (used by MOVHI)
- reg_wr_en  out  1  register write strobe
- reg_wr_addr  out  REG_AW  register write address
- reg_wr_data  out  DATA_W  register write data
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done for a rejected encoding

Behaviour:
- Reset:
  - `reset` low forces IDLE asynchronously.
  - Clears the accumulator, word counter and latched mode/nwords/dest.
  - All outputs go to 0, including reg_wr_addr and reg_wr_data.
  - Reset mid-instruction aborts it with no register write and no further pc_inc.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - busy=0.
  - On start=1, mode, nwords and dest_addr are latched.
  - Illegal encoding: mode==11, nwords==0, or nwords>MAX_WORDS. Next state is DONE with illegal latched; no fetch, no write, no pc_inc.
  - Otherwise next state is FETCH; accumulator and counter are cleared.
- FETCH:
  - imm_req=1 and busy=1.
  - Each cycle with imm_valid=1:
    - acc <= (acc << IMM_W) | imm_data (first word is most significant).
    - count++.
    - pc_inc=1 combinationally in that same cycle.
  - After the nwords-th accepted word, next state is WRITE.
  - imm_valid low: hold state, no pc_inc. There is no timeout.
- WRITE:
  - reg_wr_en=1 for exactly one cycle; reg_wr_addr = latched dest.
  - Loaded width L = nwords*IMM_W, bits acc[L-1:0].
  - mode 00: zero-extend (or truncate) to DATA_W.
  - mode 01: sign-extend from bit L-1 (truncate if L>DATA_W).
  - mode 10: upper DATA_W/2 bits = acc[DATA_W/2-1:0]; lower half = reg_rd_data[DATA_W/2-1:0], sampled in the WRITE cycle.
  - Next state is DONE.
- DONE:
  - done=1 for one cycle; illegal=1 in the same cycle if the encoding was rejected.
  - busy=0 in DONE. Next state is IDLE.
- Latency:
  - Legal instruction with zero-wait memory: done asserts nwords+2 cycles after the start-sampling edge.
  - Illegal encoding: done and illegal assert 1 cycle after that edge.
- Ignored inputs:
  - start outside IDLE is ignored, with no queueing.
  - imm_valid outside FETCH is ignored.
  - mode/nwords/dest_addr changes after latching have no effect.
- Output registration:
  - reg_wr_data/reg_wr_addr hold their last values outside WRITE; only reg_wr_en qualifies them.
  - done, illegal and reg_wr_en are registered, glitch-free state decodes.

Test Plan (DATA_W=16, IMM_W=8, MAX_WORDS=2):
- Zero-extend, one word: mode=00, nwords=1, dest=3, imm 0x85 valid immediately.
  -> one pc_inc pulse; reg_wr_en with addr 3, data 0x0085; done 3 cycles after start; illegal=0.
- Sign-extend, one word: mode=01, nwords=1, imm 0x85.
  -> data 0xFF85. Repeat with imm 0x45 -> 0x0045.
- Two words with memory wait: mode=00, nwords=2; 0x12 accepted, 2-cycle imm_valid gap, then 0x34.
  -> imm_req held through the gap; exactly 2 pc_inc pulses; data 0x1234; done 6 cycles after start.
- MOVHI: mode=10, nwords=1, reg_rd_data=0xABCD, imm 0x5E.
  -> data 0x5ECD written once.
- Illegal encodings, each tried separately: mode=11; nwords=0; nwords=3.
  -> done and illegal pulse together 1 cycle after start; no reg_wr_en, no pc_inc, no imm_req. A start pulse during busy is ignored.
- Reset mid-instruction: assert reset low in FETCH after the first of 2 words.
  -> all outputs 0 immediately, asynchronously; no reg_wr_en. After release, a fresh mode=00, nwords=1, imm 0x7F instruction writes 0x007F normally.
